alu_word_sequencer: RTL and testbench

//  Multi-byte operation sequencer for the 8-bit combinational ALU. Accepts one (8*WORDS)-bit op
//  per valid/ready handshake and drives the ALU byte-serially, one byte per cycle.

---
 rtl/alu_word_sequencer.sv | 117 +++++++++++
 tb/tb_alu_word_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - byte-serial sequencer driving the 8-bit ALU for WORDS-byte operations.
package alu_word_sequencer_pkg;
  localparam logic [2:0] kAND = 3'd0;
  localparam logic [2:0] kLSH = 3'd1;
  localparam logic [2:0] kRSH = 3'd2;
  localparam logic [2:0] kXOR = 3'd3;
endpackage

module alu_word_sequencer
  import alu_word_sequencer_pkg::*;
#(
  parameter int WORDS = 2
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [2:0]           REQ_OP,
  input  logic [8*WORDS-1:0]   REQ_A,
  input  logic [8*WORDS-1:0]   REQ_B,
  input  logic                 REQ_CIN,
  output logic [7:0]           ALU_A,
  output logic [7:0]           ALU_B,
  output logic [2:0]           ALU_OP,
  output logic                 ALU_SC_IN,
  input  logic [7:0]           ALU_OUT,
  input  logic                 ALU_SC_OUT,
  input  logic                 ALU_ODD,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [8*WORDS-1:0]   RSP_DATA,
  output logic                 RSP_CARRY,
  output logic                 RSP_ZERO,
  output logic                 RSP_ODD
);
  localparam int W     = 8 * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, byte_sel;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q, b_q, result;
  logic             carry, parity;
  logic             last;

  assign last = (idx == IDX_W'(WORDS - 1));

  // Right shifts walk from the MS byte down so the carry chain flows toward bit 0.
  always_comb begin
    byte_sel = idx;
    if (op_q == kRSH) byte_sel = IDX_W'(WORDS - 1) - idx;
  end

  always_comb begin
    state_nxt = state;
    REQ_READY = 1'b0;
    RSP_VALID = 1'b0;
    ALU_A     = 8'h00;
    ALU_B     = 8'h00;
    ALU_OP    = kAND;
    ALU_SC_IN = 1'b0;
    case (state)
      IDLE: begin
        REQ_READY = 1'b1;
        if (REQ_VALID) state_nxt = EXEC;
      end
      EXEC: begin
        ALU_A     = a_q[byte_sel*8 +: 8];
        ALU_B     = b_q[byte_sel*8 +: 8];
        ALU_OP    = op_q;
        ALU_SC_IN = carry;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      idx    <= '0;
      op_q   <= kAND;
      a_q    <= '0;
      b_q    <= '0;
      result <= '0;
      carry  <= 1'b0;
      parity <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && REQ_VALID) begin
        op_q   <= REQ_OP;
        a_q    <= REQ_A;
        b_q    <= REQ_B;
        carry  <= REQ_CIN;
        result <= '0;
        parity <= 1'b0;
        idx    <= '0;
      end else if (state == EXEC) begin
        result[byte_sel*8 +: 8] <= ALU_OUT;
        carry  <= ALU_SC_OUT;
        parity <= parity ^ ALU_ODD;
        idx    <= last ? '0 : idx + 1'b1;
      end
    end
  end

  assign RSP_DATA  = result;
  assign RSP_CARRY = carry;
  assign RSP_ZERO  = (result == '0);
  assign RSP_ODD   = parity;
endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb/tb_alu_word_sequencer.sv - randomized and directed bench for alu_word_sequencer with a word-level model.
module tb_alu_word_sequencer;
  import alu_word_sequencer_pkg::*;

  localparam int WORDS = 2;
  localparam int W     = 8 * WORDS;

  logic         CLK = 1'b0;
  logic         RESET_N;
  logic         REQ_VALID;
  logic         REQ_READY;
  logic [2:0]   REQ_OP;
  logic [W-1:0] REQ_A, REQ_B;
  logic         REQ_CIN;
  logic [7:0]   ALU_A, ALU_B, ALU_OUT;
  logic [2:0]   ALU_OP;
  logic         ALU_SC_IN, ALU_SC_OUT, ALU_ODD;
  logic         RSP_VALID, RSP_READY;
  logic [W-1:0] RSP_DATA;
  logic         RSP_CARRY, RSP_ZERO, RSP_ODD;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  typedef struct {
    int           acc;
    logic [2:0]   op;
    logic [W-1:0] a, b, data;
    logic         cin, carry, zero, odd;
  } exp_t;

  exp_t exp_q[$];

  alu_word_sequencer #(.WORDS(WORDS)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
    .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_CIN(REQ_CIN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OP(ALU_OP), .ALU_SC_IN(ALU_SC_IN),
    .ALU_OUT(ALU_OUT), .ALU_SC_OUT(ALU_SC_OUT), .ALU_ODD(ALU_ODD),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_CARRY(RSP_CARRY), .RSP_ZERO(RSP_ZERO), .RSP_ODD(RSP_ODD)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cycle <= cycle + 1;

  // 8-bit combinational ALU the sequencer drives
  always_comb begin
    ALU_OUT    = 8'h00;
    ALU_SC_OUT = 1'b0;
    case (ALU_OP)
      kAND: ALU_OUT = ALU_A & ALU_B;
      kXOR: ALU_OUT = ALU_A ^ ALU_B;
      kLSH: begin ALU_OUT = {ALU_A[6:0], ALU_SC_IN}; ALU_SC_OUT = ALU_A[7]; end
      kRSH: begin ALU_OUT = {ALU_SC_IN, ALU_A[7:1]}; ALU_SC_OUT = ALU_A[0]; end
      default: ;
    endcase
    ALU_ODD = ^ALU_OUT;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cycle, act, req);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input int acc);
    exp_t e;
    e.acc = acc; e.op = op; e.a = a; e.b = b; e.cin = cin;
    e.data = '0; e.carry = 1'b0;
    case (op)
      kAND: e.data = a & b;
      kXOR: e.data = a ^ b;
      kLSH: begin e.data = (a << 1) | W'(cin); e.carry = a[W-1]; end
      kRSH: begin e.data = (a >> 1) | (W'(cin) << (W - 1)); e.carry = a[0]; end
      default: ;
    endcase
    e.zero = (e.data == '0);
    e.odd  = ^e.data;
    return e;
  endfunction

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int k);
    return 8'(v >> (8 * k));
  endfunction

  // Word-level scoreboard: an accepted op occupies WORDS cycles of ALU traffic, then answers.
  always @(negedge CLK) begin : cmp
    exp_t e;
    int   j, k;
    if (!RESET_N) begin
      exp_q.delete();
      check("rst_req_ready", REQ_READY, 1);
      check("rst_rsp_valid", RSP_VALID, 0);
      check("rst_alu_a", ALU_A, 0);
    end else begin
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        j = cycle - e.acc;
        check("busy_req_ready", REQ_READY, 0);
        if (j < WORDS) begin
          k = (e.op == kRSH) ? WORDS - 1 - j : j;
          check("exec_rsp_valid", RSP_VALID, 0);
          check("exec_alu_a", ALU_A, byte_of(e.a, k));
          check("exec_alu_b", ALU_B, byte_of(e.b, k));
          check("exec_alu_op", ALU_OP, e.op);
          if (j == 0) check("exec_sc_in0", ALU_SC_IN, e.cin);
        end else begin
          check("rsp_valid", RSP_VALID, 1);
          if (RSP_VALID) begin
            check("rsp_data", RSP_DATA, e.data);
            check("rsp_carry", RSP_CARRY, e.carry);
            check("rsp_zero", RSP_ZERO, e.zero);
            check("rsp_odd", RSP_ODD, e.odd);
            if (RSP_READY) void'(exp_q.pop_front());
          end
        end
      end else begin
        check("idle_req_ready", REQ_READY, 1);
        check("idle_rsp_valid", RSP_VALID, 0);
        check("idle_alu_a", ALU_A, 0);
        check("idle_alu_b", ALU_B, 0);
        check("idle_alu_op", ALU_OP, kAND);
        check("idle_sc_in", ALU_SC_IN, 0);
      end
      if (REQ_VALID && REQ_READY) exp_q.push_back(model(REQ_OP, REQ_A, REQ_B, REQ_CIN, cycle + 1));
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int t;
    REQ_OP = op; REQ_A = a; REQ_B = b; REQ_CIN = cin; REQ_VALID = 1'b1;
    t = 0;
    @(negedge CLK);
    while (!REQ_READY && t < 50) begin @(negedge CLK); t++; end
    if (!REQ_READY) check("accept_timeout", 0, 1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  // Returns on the falling edge where RSP_VALID is seen high.
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge CLK);
    while (!RSP_VALID && n < 20) begin @(negedge CLK); n++; end
    if (!RSP_VALID) check("rsp_timeout", 0, 1);
  endtask

  task automatic check_rsp(input string tag, input logic [W-1:0] d, input logic c, input logic z, input logic o);
    check({tag, "_data"}, RSP_DATA, d);
    check({tag, "_carry"}, RSP_CARRY, c);
    check({tag, "_zero"}, RSP_ZERO, z);
    check({tag, "_odd"}, RSP_ODD, o);
  endtask

  function automatic logic [2:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    return (r < 8) ? 3'(r % 4) : 3'($urandom_range(4, 7));
  endfunction

  initial begin
    int n, t, prev, acc;
    logic took;
    RESET_N = 1'b0; REQ_VALID = 1'b0; REQ_OP = kAND; REQ_A = '0; REQ_B = '0; REQ_CIN = 1'b0;
    RSP_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RESET_N = 1'b1;
    @(negedge CLK);
    check("reset_req_ready", REQ_READY, 1);
    check("reset_rsp_data", RSP_DATA, 0);
    @(posedge CLK); #1;

    send(kLSH, 16'h80C1, 16'h0000, 1'b1);
    wait_rsp(n);
    check("lsh_latency", n, 2);
    check_rsp("lsh", 16'h0183, 1, 0, 0);
    @(posedge CLK); #1;

    send(kRSH, 16'h0103, 16'h0000, 1'b1);
    @(negedge CLK);
    check("rsh_first_byte", ALU_A, 8'h01);
    wait_rsp(n);
    check_rsp("rsh", 16'h8081, 1, 0, 1);
    @(posedge CLK); #1;

    send(kXOR, 16'h5AA5, 16'h5AA5, 1'b1);
    wait_rsp(n);
    check_rsp("xor", 16'h0000, 0, 1, 0);
    @(posedge CLK); #1;
    send(kAND, 16'hF0F0, 16'h3C0F, 1'b0);
    wait_rsp(n);
    check_rsp("and", 16'h3000, 0, 0, 0);
    @(posedge CLK); #1;

    RSP_READY = 1'b0;
    send(kXOR, 16'h1234, 16'h00FF, 1'b0);
    wait_rsp(n);
    @(posedge CLK); #1;
    REQ_OP = kAND; REQ_A = 16'hFFFF; REQ_B = 16'h00FF; REQ_CIN = 1'b0; REQ_VALID = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      check("stall_rsp_valid", RSP_VALID, 1);
      check("stall_req_ready", REQ_READY, 0);
      check("stall_data", RSP_DATA, 16'h12CB);
      check("stall_odd", RSP_ODD, 1);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    send(kAND, 16'hFFFF, 16'h00FF, 1'b0);
    wait_rsp(n);
    check_rsp("after_stall", 16'h00FF, 0, 0, 0);
    @(posedge CLK); #1;

    send(kLSH, 16'h4242, 16'h0000, 1'b0);
    @(posedge CLK); #1;
    RESET_N = 1'b0;
    @(negedge CLK);
    check("midrst_req_ready", REQ_READY, 1);
    check("midrst_rsp_valid", RSP_VALID, 0);
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("postrst_no_rsp", RSP_VALID, 0);
    end
    @(posedge CLK); #1;
    send(kLSH, 16'h0001, 16'h0000, 1'b0);
    wait_rsp(n);
    check_rsp("postrst_lsh", 16'h0002, 0, 0, 1);
    @(posedge CLK); #1;

    send(3'b111, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_rsp(n);
    check_rsp("invalid", 16'h0000, 0, 1, 0);

    @(posedge CLK); #1;
    REQ_VALID = 1'b1; REQ_OP = rand_op(); REQ_A = W'($urandom); REQ_B = W'($urandom); REQ_CIN = 1'($urandom);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      t = 0;
      @(negedge CLK);
      while (!REQ_READY && t < 20) begin @(negedge CLK); t++; end
      if (!REQ_READY) check("b2b_timeout", 0, 1);
      acc = cycle;
      if (i > 0) check("b2b_gap", acc - prev, WORDS + 2);
      prev = acc;
      @(posedge CLK); #1;
      REQ_OP = rand_op(); REQ_A = W'($urandom); REQ_B = W'($urandom); REQ_CIN = 1'($urandom);
    end
    REQ_VALID = 1'b0;

    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      took = REQ_VALID && REQ_READY;
      @(posedge CLK); #1;
      RSP_READY = ($urandom_range(0, 3) != 0);
      if (took || !REQ_VALID) begin
        REQ_VALID = ($urandom_range(0, 2) != 0);
        REQ_OP = rand_op(); REQ_A = W'($urandom); REQ_B = W'($urandom); REQ_CIN = 1'($urandom);
      end
    end

    REQ_VALID = 1'b0;
    RSP_READY = 1'b1;
    repeat (10) @(posedge CLK);
    @(negedge CLK);
    check("drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
